// File: rtl/term_seq_pkg.sv
// Shared types and widths for the term multiplier sequencer.
// term_t is the packed term encoding and state_e is the scheduler state.
// The helper functions derive TERM_W and ACC_W from the base parameters.
package term_seq_pkg;

    localparam int A_N       = 4;
    localparam int N         = 3;
    localparam int MAX_TERMS = 4;

    function automatic int term_w(input int n);
        return 2 + 2 * n;
    endfunction

    // One extra magnitude bit per doubling of the term count, plus a sign bit.
    function automatic int acc_w(input int a_n, input int n, input int max_terms);
        return a_n + (1 << n) + $clog2(max_terms) + 1;
    endfunction

    localparam int TERM_W = term_w(N);
    localparam int P      = A_N + (1 << N);
    localparam int ACC_W  = acc_w(A_N, N, MAX_TERMS);
    localparam int CNT_W  = $clog2(MAX_TERMS + 1);
    localparam int IDX_W  = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

    typedef struct packed {
        logic         one_term;
        logic         b_sign;
        logic [N-1:0] b_i;
        logic [N-1:0] b_j;
    } term_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/term_seq_acc.sv
// Partial-product accumulator for the term multiplier sequencer.
// Widens the multiplier product to ACC_W and adds it when add_en is high.
// Only a two-term difference product can be negative; every other product is
// unsigned and may use the full P bits, so it must be zero-extended.
module term_seq_acc
    import term_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic             one_term,
    input  logic             b_sign,
    input  logic [P-1:0]     mul_c,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] addend;

    // Select sign- or zero-extension of the product.
    always_comb begin
        // NOTE: assign a default before any condition in combinational blocks so no path leaves the signal unassigned (which would infer a latch).
        addend = {{(ACC_W-P){1'b0}}, mul_c};
        if (!one_term && b_sign) begin
            addend = {{(ACC_W-P){mul_c[P-1]}}, mul_c};
        end
    end

    // Accumulator register: clear on a new job, add on each accepted product.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + addend;
        end
    end

endmodule

// File: rtl/term_mult_sequencer.sv
// Serial scheduler for the shift-add term multiplier.
// Accepts one job (multiplicand plus up to MAX_TERMS terms), issues one term
// per cycle to the external multiplier, accumulates the products and returns
// the signed sum over a valid/ready handshake.
// Optional feature macro: TERM_MULT_SEQ_PERF_EN adds perf_busy_cycles and
// perf_jobs counters; without it those ports do not exist.
module term_mult_sequencer
    import term_seq_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic [A_N-1:0]              req_a,
    input  logic [MAX_TERMS*TERM_W-1:0] req_terms,
    input  logic [CNT_W-1:0]            req_num_terms,
    output logic [A_N-1:0]              mul_a,
    output logic [N-1:0]                mul_b_i,
    output logic [N-1:0]                mul_b_j,
    output logic                        mul_one_term,
    output logic                        mul_b_sign,
    output logic                        mul_vld,
    input  logic [P-1:0]                mul_c,
    input  logic                        mul_result_vld,
    output logic                        res_vld,
    input  logic                        res_rdy,
    output logic [ACC_W-1:0]            res_data
`ifdef TERM_MULT_SEQ_PERF_EN
    ,
    output logic [31:0]                 perf_busy_cycles,
    output logic [31:0]                 perf_jobs
`endif
);

    state_e           state_q;
    state_e           state_d;
    logic [A_N-1:0]   a_q;
    term_t            terms_q [MAX_TERMS];
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;

    logic             accept;
    logic [CNT_W-1:0] req_cnt;
    term_t            cur_term;
    logic             last_term;
    logic             add_en;

    // Job decode: clamp the term count and find the term currently issued.
    always_comb begin
        req_cnt   = (req_num_terms > CNT_W'(MAX_TERMS)) ? CNT_W'(MAX_TERMS) : req_num_terms;
        accept    = req_vld && req_rdy;
        cur_term  = terms_q[idx_q];
        last_term = (CNT_W'(idx_q) == (cnt_q - CNT_W'(1)));
        add_en    = (state_q == ISSUE) && mul_result_vld;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (req_cnt == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (mul_result_vld && last_term) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshakes plus multiplier operands, zero while no term is issued.
    always_comb begin
        req_rdy      = (state_q == IDLE) && !rst;
        res_vld      = (state_q == DONE);
        mul_vld      = (state_q == ISSUE);
        mul_a        = '0;
        mul_b_i      = '0;
        mul_b_j      = '0;
        mul_one_term = 1'b0;
        mul_b_sign   = 1'b0;
        if (state_q == ISSUE) begin
            mul_a        = a_q;
            mul_b_i      = cur_term.b_i;
            mul_b_j      = cur_term.b_j;
            mul_one_term = cur_term.one_term;
            mul_b_sign   = cur_term.b_sign;
        end
    end

    // Job capture: multiplicand, term array and clamped count.
    always_ff @(posedge clk) begin
        // NOTE: these data registers are left unreset; they are always written on accept before use, and the operand ports are gated to 0 outside ISSUE.
        if (accept) begin
            a_q   <= req_a;
            cnt_q <= req_cnt;
            for (int k = 0; k < MAX_TERMS; k++) begin
                terms_q[k] <= term_t'(req_terms[k*TERM_W +: TERM_W]);
            end
        end
    end

    // Term index: restart on accept, advance on each accepted product.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            idx_q <= '0;
        end else if (add_en && !last_term) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    term_seq_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (accept),
        .add_en   (add_en),
        .one_term (cur_term.one_term),
        .b_sign   (cur_term.b_sign),
        .mul_c    (mul_c),
        .acc      (res_data)
    );

`ifdef TERM_MULT_SEQ_PERF_EN
    // Performance counters: cycles in ISSUE and completed result handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_jobs        <= '0;
        end else begin
            if (state_q == ISSUE) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (res_vld && res_rdy) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_term_mult_sequencer.sv
// Self-checking bench for term_mult_sequencer.
// Includes a behavioural model of the external multiplier, a table of directed
// jobs, hand-written reset/stall sequences and randomized jobs checked against
// an arithmetic reference of the job result.
module tb_term_mult_sequencer;
    import term_seq_pkg::*;

    localparam int TW = MAX_TERMS * TERM_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_vld;
    logic             req_rdy;
    logic [A_N-1:0]   req_a;
    logic [TW-1:0]    req_terms;
    logic [CNT_W-1:0] req_num_terms;
    logic [A_N-1:0]   mul_a;
    logic [N-1:0]     mul_b_i;
    logic [N-1:0]     mul_b_j;
    logic             mul_one_term;
    logic             mul_b_sign;
    logic             mul_vld;
    logic [P-1:0]     mul_c;
    logic             mul_result_vld;
    logic             res_vld;
    logic             res_rdy;
    logic [ACC_W-1:0] res_data;
    logic             stall = 1'b0;
    int               prod;

    int errors = 0;
    int checks = 0;

`ifdef TERM_MULT_SEQ_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [31:0] perf_jobs;
    int          busy_model = 0;
    int          jobs_model = 0;
`endif

    term_mult_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_a          (req_a),
        .req_terms      (req_terms),
        .req_num_terms  (req_num_terms),
        .mul_a          (mul_a),
        .mul_b_i        (mul_b_i),
        .mul_b_j        (mul_b_j),
        .mul_one_term   (mul_one_term),
        .mul_b_sign     (mul_b_sign),
        .mul_vld        (mul_vld),
        .mul_c          (mul_c),
        .mul_result_vld (mul_result_vld),
        .res_vld        (res_vld),
        .res_rdy        (res_rdy),
        .res_data       (res_data)
`ifdef TERM_MULT_SEQ_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
`endif
    );

    always #5 clk = ~clk;

    // Weight of one term: 2^i, 2^i + 2^j or 2^i - 2^j.
    function automatic int term_value(input logic [TERM_W-1:0] t);
        term_t tt;
        tt = term_t'(t);
        if (tt.one_term) return 1 << tt.b_i;
        if (tt.b_sign)   return (1 << tt.b_i) - (1 << tt.b_j);
        return (1 << tt.b_i) + (1 << tt.b_j);
    endfunction

    // Reference result of a whole job, count clamped to MAX_TERMS.
    function automatic int ref_model(input int a, input logic [TW-1:0] terms, input int num);
        int k;
        int sum;
        k   = (num > MAX_TERMS) ? MAX_TERMS : num;
        sum = 0;
        for (int i = 0; i < k; i++) begin
            sum += a * term_value(terms[i*TERM_W +: TERM_W]);
        end
        return sum;
    endfunction

    function automatic logic [TERM_W-1:0] mk(input bit one, input bit sgn, input int bi, input int bj);
        term_t t;
        t.one_term = one;
        t.b_sign   = sgn;
        t.b_i      = N'(bi);
        t.b_j      = N'(bj);
        return t;
    endfunction

    // External multiplier: combinational product truncated to P bits.
    always_comb begin
        prod  = int'(mul_a) * term_value({mul_one_term, mul_b_sign, mul_b_i, mul_b_j});
        mul_c = prod[P-1:0];
    end
    assign mul_result_vld = mul_vld & ~stall;

`ifdef TERM_MULT_SEQ_PERF_EN
    always @(posedge clk) begin
        if (rst) begin
            busy_model = 0;
            jobs_model = 0;
        end else begin
            if (mul_vld) busy_model++;
            if (res_vld && res_rdy) jobs_model++;
        end
    end
`endif

    task automatic check(input string name, input int act, input int expected);
        checks++;
        if (act !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one job end to end; hold delays res_rdy for that many DONE cycles.
    task automatic run_job(input string name, input logic [A_N-1:0] a, input logic [TW-1:0] terms,
                           input logic [CNT_W-1:0] num, input int expected, input bit stall_en,
                           input int hold);
        int    k;
        int    n;
        int    cyc;
        int    issued;
        term_t t_exp;
        k = (int'(num) > MAX_TERMS) ? MAX_TERMS : int'(num);
        n = 0;
        while (!req_rdy && n < 20) begin
            step();
            n++;
        end
        check({name, " req_rdy before accept"}, int'(req_rdy), 1);
        req_vld       = 1'b1;
        req_a         = a;
        req_terms     = terms;
        req_num_terms = num;
        step();
        req_vld = 1'b0;
        cyc     = 1;
        issued  = 0;
        stall   = stall_en && ($urandom_range(0, 1) == 0);
        #0;
        while (!res_vld && cyc < 60) begin
            if (mul_vld && issued < k) begin
                t_exp = term_t'(terms[issued*TERM_W +: TERM_W]);
                check({name, " issued term"}, int'({mul_one_term, mul_b_sign, mul_b_i, mul_b_j}), int'(t_exp));
                check({name, " mul_a"}, int'(mul_a), int'(a));
            end
            if (mul_result_vld) issued++;
            step();
            cyc++;
            stall = stall_en && ($urandom_range(0, 1) == 0);
            #0;
        end
        stall = 1'b0;
        check({name, " accepted products"}, issued, k);
        if (!stall_en) check({name, " result cycle"}, cyc, k + 1);
        check({name, " res_vld"}, int'(res_vld), 1);
        check({name, " res_data"}, int'($signed(res_data)), expected);
        check({name, " req_rdy in DONE"}, int'(req_rdy), 0);
        for (int i = 0; i < hold; i++) begin
            step();
            check({name, " res_vld held"}, int'(res_vld), 1);
            check({name, " res_data held"}, int'($signed(res_data)), expected);
            check({name, " req_rdy held"}, int'(req_rdy), 0);
        end
        res_rdy = 1'b1;
        step();
        res_rdy = 1'b0;
        check({name, " res_vld after handshake"}, int'(res_vld), 0);
        check({name, " req_rdy after handshake"}, int'(req_rdy), 1);
        check({name, " idle operands"}, int'({mul_vld, mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign}), 0);
    endtask

    typedef struct {
        logic [A_N-1:0]   a;
        logic [TW-1:0]    terms;
        logic [CNT_W-1:0] num;
        int               expected;
        bit               stall_en;
        int               hold;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [A_N-1:0]   ra;
        logic [TW-1:0]    rterms;
        logic [CNT_W-1:0] rnum;

        vecs[0] = '{4'd5,  {TERM_W'(0), TERM_W'(0), TERM_W'(0), mk(1, 0, 2, 0)}, 3'd1, 20, 1'b0, 0};
        vecs[1] = '{4'd5,  {TERM_W'(0), TERM_W'(0), mk(1, 0, 1, 0), mk(0, 1, 3, 0)}, 3'd2, 45, 1'b0, 0};
        vecs[2] = '{4'd15, {TERM_W'(0), TERM_W'(0), TERM_W'(0), mk(0, 1, 0, 7)}, 3'd1, -1905, 1'b0, 0};
        vecs[3] = '{4'd15, {mk(0, 0, 7, 7), mk(0, 0, 7, 7), mk(0, 0, 7, 7), mk(0, 0, 7, 7)}, 3'd4, 15360, 1'b0, 0};
        vecs[4] = '{4'd9,  TW'(0), 3'd0, 0, 1'b0, 3};
        vecs[5] = '{4'd3,  {mk(1, 0, 3, 0), mk(1, 0, 2, 0), mk(1, 0, 1, 0), mk(1, 0, 0, 0)}, 3'd7, 45, 1'b0, 0};
        vecs[6] = '{4'd11, {mk(0, 1, 6, 6), mk(0, 0, 0, 1), mk(1, 1, 4, 0), mk(0, 1, 2, 5)}, 3'd4, -99, 1'b1, 1};

        rst           = 1'b1;
        req_vld       = 1'b0;
        req_a         = '0;
        req_terms     = '0;
        req_num_terms = '0;
        res_rdy       = 1'b0;
        step();
        step();
        check("reset req_rdy", int'(req_rdy), 0);
        check("reset mul_vld", int'(mul_vld), 0);
        check("reset res_vld", int'(res_vld), 0);
        check("reset res_data", int'(res_data), 0);
        check("reset operands", int'({mul_a, mul_b_i, mul_b_j, mul_one_term, mul_b_sign}), 0);
        rst = 1'b0;
        #1;
        check("req_rdy after reset", int'(req_rdy), 1);

        for (int i = 0; i < 7; i++) begin
            run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].terms, vecs[i].num,
                    vecs[i].expected, vecs[i].stall_en, vecs[i].hold);
        end

        // Reset during the second of four terms drops the job.
        req_vld       = 1'b1;
        req_a         = 4'd7;
        req_terms     = {4{mk(1, 0, 1, 0)}};
        req_num_terms = 3'd4;
        step();
        req_vld = 1'b0;
        step();
        check("midrst term2 issuing", int'(mul_vld), 1);
        rst = 1'b1;
        step();
        check("midrst mul_vld", int'(mul_vld), 0);
        check("midrst res_vld", int'(res_vld), 0);
        check("midrst req_rdy during rst", int'(req_rdy), 0);
        rst = 1'b0;
        #1;
        check("midrst req_rdy after rst", int'(req_rdy), 1);
        step();
        check("midrst no result", int'(res_vld), 0);
        run_job("after_rst", 4'd6, {mk(0, 1, 1, 3), mk(1, 0, 0, 0), mk(0, 0, 2, 2), mk(1, 1, 5, 0)},
                3'd4, ref_model(6, {mk(0, 1, 1, 3), mk(1, 0, 0, 0), mk(0, 0, 2, 2), mk(1, 1, 5, 0)}, 4),
                1'b0, 0);

        // Randomized jobs against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            ra     = A_N'($urandom);
            rterms = TW'($urandom);
            rnum   = CNT_W'($urandom_range(0, 5));
            if (rnum == 3'd5) rnum = CNT_W'($urandom_range(5, 7));
            run_job($sformatf("rand%0d", i), ra, rterms, rnum, ref_model(int'(ra), rterms, int'(rnum)),
                    ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
        end

`ifdef TERM_MULT_SEQ_PERF_EN
        check("perf_busy_cycles", int'(perf_busy_cycles), busy_model);
        check("perf_jobs", int'(perf_jobs), jobs_model);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
